// File: rtl/pipelined_cla_addsub_if.sv
// pipelined_cla_addsub_if: operand and result stream bundle for pipelined_cla_addsub
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid, in_ready, in_sub, in_cin;
    logic [WIDTH-1:0] in_a, in_b, out_sum;
    logic             out_valid, out_ready, out_cout, out_ovf, out_zero;
    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: pipelined carry-lookahead adder/subtractor with valid/ready streams
module pipelined_cla_addsub #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input logic                   clk,
    input logic                   rst,
    pipelined_cla_addsub_if.slave io_bus
);
    localparam int N  = WIDTH / GROUP / STAGES;
    localparam int SW = N * GROUP;
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // stage k sees only the still-unresolved high operand bits, resolved slice is the low SW of them
        localparam int RW = WIDTH - k * SW;
        logic [RW-1:0]       w_a, w_b;
        logic                w_c, w_v, w_adv, w_gg, w_gp;
        logic [SW-1:0]       w_p, w_g, w_sl, w_bc;
        logic [N:0]          w_gc;
        logic [(k+1)*SW-1:0] w_ns;
        logic                r_v, r_c;
        logic [(k+1)*SW-1:0] r_s;
        if (k == 0) begin : g_in
            assign w_v  = io_bus.in_valid;
            assign w_a  = io_bus.in_a;
            assign w_b  = io_bus.in_sub ? ~io_bus.in_b : io_bus.in_b;
            assign w_c  = io_bus.in_sub ^ io_bus.in_cin;
            assign w_ns = w_sl;
        end else begin : g_mid
            assign w_v  = g_st[k-1].r_v;
            assign w_a  = g_st[k-1].g_fw.r_a;
            assign w_b  = g_st[k-1].g_fw.r_b;
            assign w_c  = g_st[k-1].r_c;
            assign w_ns = {w_sl, g_st[k-1].r_s};
        end
        assign w_p  = w_a[SW-1:0] ^ w_b[SW-1:0];
        assign w_g  = w_a[SW-1:0] & w_b[SW-1:0];
        assign w_sl = w_p ^ w_bc;
        always_comb begin
            w_gc    = '0;
            w_bc    = '0;
            w_gg    = 1'b0;
            w_gp    = 1'b1;
            w_gc[0] = w_c;
            for (int j = 0; j < N; j++) begin
                w_gg = 1'b0;
                w_gp = 1'b1;
                for (int i = 0; i < GROUP; i++) begin
                    w_gg = w_g[j*GROUP+i] | (w_p[j*GROUP+i] & w_gg);
                    w_gp = w_gp & w_p[j*GROUP+i];
                end
                w_gc[j+1]     = w_gg | (w_gp & w_gc[j]);
                w_bc[j*GROUP] = w_gc[j];
                for (int i = 0; i < GROUP - 1; i++)
                    w_bc[j*GROUP+i+1] = w_g[j*GROUP+i] | (w_p[j*GROUP+i] & w_bc[j*GROUP+i]);
            end
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else begin
                if (w_adv) r_v <= w_v;
                if (w_adv && w_v) begin
                    r_c <= w_gc[N];
                    r_s <= w_ns;
                end
            end
        end
        if (k == STAGES - 1) begin : g_out
            logic r_ovf, r_zero;
            assign w_adv = !r_v || io_bus.out_ready;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv && w_v) begin
                    r_ovf  <= (w_a[RW-1] == w_b[RW-1]) && (w_ns[WIDTH-1] != w_a[RW-1]);
                    r_zero <= ~|w_ns;
                end
            end
        end else begin : g_fw
            logic [RW-SW-1:0] r_a, r_b;
            assign w_adv = !r_v || g_st[k+1].w_adv;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv && w_v) begin
                    r_a <= w_a[RW-1:SW];
                    r_b <= w_b[RW-1:SW];
                end
            end
        end
    end
    assign io_bus.in_ready  = g_st[0].w_adv;
    assign io_bus.out_valid = g_st[STAGES-1].r_v;
    assign io_bus.out_sum   = g_st[STAGES-1].r_s;
    assign io_bus.out_cout  = g_st[STAGES-1].r_c;
    assign io_bus.out_ovf   = g_st[STAGES-1].g_out.r_ovf;
    assign io_bus.out_zero  = g_st[STAGES-1].g_out.r_zero;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: directed and random checks of pipelined_cla_addsub against an arithmetic model
module tb_pipelined_cla_addsub;
    localparam int NC = 6;
    localparam int CW [NC] = '{16, 32, 32, 32, 32, 32};
    localparam int CG [NC] = '{4, 2, 4, 8, 2, 8};
    localparam int CS [NC] = '{2, 1, 2, 4, 4, 1};
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;
    logic clk = 1'b0, rst = 1'b1, lat_chk = 1'b0;
    logic s_v [NC], s_sub [NC], s_cin [NC], s_or [NC];
    logic [31:0] s_a [NC], s_b [NC];
    logic [NC-1:0] o_ir, o_vld, o_cout, o_ovf, o_zero;
    logic [NC-1:0][31:0] o_sum;
    int n_in [NC] = '{default: 0};
    int n_out [NC] = '{default: 0};
    int n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // signed/unsigned integer arithmetic, independent of any bit-level carry structure
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin);
        longint m, r, sa, sb, sr;
        res_t x;
        m  = longint'(1) << w;
        r  = sub ? longint'(a) - longint'(b) - longint'(cin) : longint'(a) + longint'(b) + longint'(cin);
        sa = longint'(a);
        sb = longint'(b);
        if (sa >= m / 2) sa -= m;
        if (sb >= m / 2) sb -= m;
        sr     = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
        x.sum  = 32'(r & (m - 1));
        x.cout = sub ? (r >= 0) : (r >= m);
        x.ovf  = (sr >= m / 2) || (sr < -(m / 2));
        x.zero = (x.sum == 32'h0);
        return x;
    endfunction

    for (genvar c = 0; c < NC; c++) begin : g_cfg
        localparam int W = CW[c];
        localparam int S = CS[c];
        pipelined_cla_addsub_if #(.WIDTH(W)) bus ();
        pipelined_cla_addsub #(.WIDTH(W), .GROUP(CG[c]), .STAGES(S)) u_dut (
            .clk(clk), .rst(rst), .io_bus(bus)
        );
        assign bus.in_valid  = s_v[c];
        assign bus.in_a      = s_a[c][W-1:0];
        assign bus.in_b      = s_b[c][W-1:0];
        assign bus.in_sub    = s_sub[c];
        assign bus.in_cin    = s_cin[c];
        assign bus.out_ready = s_or[c];
        assign o_ir[c]   = bus.in_ready;
        assign o_vld[c]  = bus.out_valid;
        assign o_sum[c]  = 32'(bus.out_sum);
        assign o_cout[c] = bus.out_cout;
        assign o_ovf[c]  = bus.out_ovf;
        assign o_zero[c] = bus.out_zero;
        initial begin
            res_t q[$];
            int qt[$];
            int cyc = 0, t;
            logic prev_rst = 1'b0, hold = 1'b0;
            logic [35:0] held = '0, cur;
            res_t e;
            forever begin
                @(negedge clk);
                cyc++;
                cur = {bus.out_valid, 32'(bus.out_sum), bus.out_cout, bus.out_ovf, bus.out_zero};
                if (prev_rst)
                    chk($sformatf("c%0d reset state", c), {bus.in_ready, cur}, {1'b1, 36'h0});
                if (hold) chk($sformatf("c%0d stall hold", c), cur, held);
                if (rst) begin
                    q.delete();
                    qt.delete();
                    n_in[c] = n_out[c];
                end else begin
                    if (bus.out_valid && bus.out_ready) begin
                        chk($sformatf("c%0d beat expected", c), 64'(q.size() != 0), 1);
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            t = qt.pop_front();
                            chk($sformatf("c%0d result", c), cur[34:0], e);
                            if (lat_chk) chk($sformatf("c%0d latency", c), cyc - t, S);
                            else chk($sformatf("c%0d latency min", c), 64'((cyc - t) >= S), 1);
                        end
                        n_out[c]++;
                    end
                    if (bus.in_valid && bus.in_ready) begin
                        q.push_back(model(W, bus.in_a, bus.in_b, bus.in_sub, bus.in_cin));
                        qt.push_back(cyc);
                        n_in[c]++;
                    end
                end
                hold     = bus.out_valid && !bus.out_ready && !rst;
                held     = cur;
                prev_rst = rst;
            end
        end
    end

    task automatic send(input int c, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin);
        int k = 0;
        s_v[c] = 1'b1; s_a[c] = a; s_b[c] = b; s_sub[c] = sub; s_cin[c] = cin;
        @(negedge clk);
        while (!o_ir[c] && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("c%0d in_ready wait", c), o_ir[c], 1);
        @(posedge clk);
        #1 s_v[c] = 1'b0;
    endtask

    task automatic drain(input int c);
        int k = 0;
        while (n_out[c] != n_in[c] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("c%0d drain", c), n_out[c], n_in[c]);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic cin, input logic [15:0] es, input logic ec, input logic eo, input logic ez);
        int k = 0;
        send(0, {16'h0, a}, {16'h0, b}, sub, cin);
        @(negedge clk);
        while (!o_vld[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " valid"}, o_vld[0], 1);
        chk(nm, {o_sum[0][15:0], o_cout[0], o_ovf[0], o_zero[0]}, {es, ec, eo, ez});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rec;
        logic saw;
        for (int i = 0; i < NC; i++) begin
            s_v[i] = 1'b0; s_sub[i] = 1'b0; s_cin[i] = 1'b0; s_or[i] = 1'b1;
            s_a[i] = '0; s_b[i] = '0;
        end
        chk("model ffff+1", model(16, 32'hFFFF, 32'h1, 1'b0, 1'b0), {32'h0, 1'b1, 1'b0, 1'b1});
        chk("model 8000-1", model(16, 32'h8000, 32'h1, 1'b1, 1'b0), {32'h7FFF, 1'b1, 1'b1, 1'b0});
        chk("model 5-7", model(16, 32'h5, 32'h7, 1'b1, 1'b0), {32'hFFFE, 1'b0, 1'b0, 1'b0});
        chk("model w32 wrap", model(32, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1), {32'h0, 1'b1, 1'b0, 1'b1});
        s_v[0] = 1'b1; s_a[0] = 32'h1234; s_b[0] = 32'h0001;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        s_v[0] = 1'b0;
        @(negedge clk);
        chk("t1 after rst", {o_ir[0], o_vld[0], o_sum[0], o_cout[0], o_ovf[0], o_zero[0]}, {1'b1, 1'b0, 32'h0, 3'b0});
        @(posedge clk);
        #1 lat_chk = 1'b1;
        lit("add ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        lit("add 7fff+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        lit("sub 0005-0007", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        lit("sub 8000-0001", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        lit("add cin", 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
        lit("sub borrow", 16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0, 1'b0);
        lit("sub 0-0-1", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        lit("add 8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        base = n_out[0];
        for (int i = 0; i < 100; i++)
            send(0, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain(0);
        chk("t4 count", n_out[0] - base, 100);
        lat_chk = 1'b0;
        base = n_out[0];
        saw = 1'b0;
        fork
            for (int i = 0; i < 20; i++)
                send(0, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            begin
                repeat (4) @(posedge clk);
                #1 s_or[0] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!o_ir[0]) saw = 1'b1;
                end
                @(posedge clk);
                #1 s_or[0] = 1'b1;
            end
        join
        drain(0);
        chk("t5 in_ready dropped", saw, 1);
        chk("t5 count", n_out[0] - base, 20);
        for (int c = 1; c < NC; c++) begin
            lat_chk = 1'b1;
            base = n_out[c];
            send(c, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
            send(c, 32'h80000000, 32'h1, 1'b1, 1'b0);
            for (int i = 0; i < 40; i++)
                send(c, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain(c);
            chk($sformatf("c%0d count", c), n_out[c] - base, 42);
            for (int i = 0; i < 6; i++)
                send(c, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            rec = n_out[c];
            repeat (10) @(posedge clk);
            #1 chk($sformatf("c%0d no stale beat", c), n_out[c] - rec, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
